multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multicycle sequencing controller for the MIPS-subset datapath: R-type, addi, lw, sw, beq, j.
- Drives a single shared ALU and one unified instruction/data memory over a req/ready handshake.
- Decodes op_i from the instruction register and steps a Moore FSM, one state per datapath phase.
- Adds memory-wait timeout detection and a retired-instruction counter.

Parameters:
MEM_WAIT_MAX, 15, max consecutive cycles mem_req_o may stay unanswered before error; 0 disables timeout
CNT_W, 8, width of internal wait counter; must hold MEM_WAIT_MAX

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-low
op_i  in  6  opcode field from instruction register
zero_i  in  1  ALU zero flag
mem_ready_i  in  1  memory completes current access this cycle
mem_req_o  out  1  memory access request
mem_we_o  out  1  1=write, 0=read; valid with mem_req_o
i_or_d_o  out  1  memory address select: 0=PC, 1=ALUOut
ir_write_o  out  1  load instruction register
pc_write_o  out  1  update PC
pc_src_o  out  2  00=ALU result, 01=ALUOut (branch target), 10=jump address
alu_src_a_o  out  1  0=PC, 1=rs
alu_src_b_o  out  2  00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
alu_op_o  out  2  00=add, 01=sub, 10=funct-decoded
reg_dst_o  out  1  0=rt, 1=rd
mem_to_reg_o  out  1  0=ALUOut, 1=memory data
reg_write_o  out  1  register file write enable
instr_done_o  out  1  one-cycle pulse on instruction retire
illegal_o  out  1  one-cycle pulse on unsupported opcode
bus_err_o  out  1  sticky memory-timeout flag
state_o  out  4  current state encoding (debug)
instr_cnt_o  out  32  retired-instruction count, wraps 2^32-1 -> 0

Behaviour:
- Reset (rst_i=0, async): state=FETCH, wait counter=0, instr_cnt_o=0, bus_err_o=0. All other outputs forced 0 combinationally while rst_i=0. Reset mid-access abandons the access; first cycle after release is FETCH.
- Encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, LW_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, I_EXEC=8, I_WB=9, BRANCH=10, JUMP=11, ERR=15. Unused codes -> FETCH next cycle, no outputs asserted.
- Outputs are Moore, except the pc_write_o / ir_write_o / instr_done_o qualifiers noted below. Any output not listed for a state is 0.
- FETCH: mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. ir_write = pc_write = mem_ready_i. Go to DECODE on mem_ready_i.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (precomputes branch target). Next state by op_i:
  - 000000 -> R_EXEC
  - 001000 -> I_EXEC
  - 100011 or 101011 -> MEM_ADDR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - other -> illegal_o=1 this cycle, back to FETCH (PC already advanced; not counted as retired).
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEM_RD if op_i=100011, else MEM_WR.
- MEM_RD: mem_req=1, mem_we=0, i_or_d=1. Go to LW_WB on ready.
- LW_WB: reg_dst=0, mem_to_reg=1, reg_write=1, instr_done=1. Go to FETCH.
- MEM_WR: mem_req=1, mem_we=1, i_or_d=1. instr_done = mem_ready_i. Go to FETCH on ready.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 -> R_WB. R_WB: reg_dst=1, reg_write=1, instr_done=1 -> FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00 -> I_WB. I_WB: reg_dst=0, reg_write=1, instr_done=1 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_write=zero_i, instr_done=1 -> FETCH.
- JUMP: pc_src=10, pc_write=1, instr_done=1 -> FETCH.
- Handshake: in FETCH/MEM_RD/MEM_WR, mem_req_o, mem_we_o and i_or_d_o hold stable until the clock edge where mem_ready_i=1. mem_ready_i is ignored in all other states.
- Wait counter:
  - Increments each memory-state cycle with mem_ready_i=0; clears on ready or on leaving the state.
  - If counter==MEM_WAIT_MAX and mem_ready_i=0 (and MEM_WAIT_MAX!=0), next state=ERR. Ready arriving in that same cycle wins: no error.
- ERR: all outputs 0 except bus_err_o=1 and state_o=15. Sticky until reset.
- instr_cnt_o increments on the edge following each instr_done_o pulse.
- Cycle counts with zero-wait memory: R/addi=4, lw=5, sw=4, beq=3, j=3.

Test Plan:
- Reset release, op_i=000000, mem_ready_i=1 -> state_o 0,1,6,7,0; reg_write_o=1 and reg_dst_o=1 only in state 7; instr_cnt_o=1.
- lw (100011), ready=1 -> states 0,1,2,3,4; mem_we_o=0 and i_or_d_o=1 in state 3; mem_to_reg_o=1 in state 4.
- beq with zero_i=1 then zero_i=0 -> pc_write_o=1, pc_src_o=01 in state 10 first time only; instr_cnt_o=2.
- sw with mem_ready_i low 3 cycles -> MEM_WR held 4 cycles, mem_req_o/mem_we_o stable, instr_done_o on 4th cycle only.
- MEM_WAIT_MAX=15, ready never asserted in FETCH -> ERR after 16 FETCH cycles, bus_err_o=1 until rst_i=0; ready on the 16th cycle -> no error.
- op_i=111111 -> illegal_o pulse in DECODE, return to FETCH, instr_cnt_o unchanged; rst_i low during MEM_RD -> all outputs 0 immediately, FETCH after release.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle sequencing controller for a MIPS-subset datapath
// (R-type, addi, lw, sw, beq, j).
//
// A Moore FSM steps one state per datapath phase. It drives a single shared ALU and one
// unified instruction/data memory over a req/ready handshake.
//
// Ports:
//   clk_i, rst_i      clock (rising edge), asynchronous active-low reset
//   op_i              opcode field from the instruction register
//   zero_i            ALU zero flag (branch decision)
//   mem_ready_i       memory completes the current access this cycle
//   mem_req_o         memory access request
//   mem_we_o          1=write, 0=read, valid with mem_req_o
//   i_or_d_o          memory address select: 0=PC, 1=ALUOut
//   ir_write_o        load instruction register
//   pc_write_o        update PC
//   pc_src_o          PC source: 00=ALU, 01=ALUOut, 10=jump address
//   alu_src_a_o       ALU A: 0=PC, 1=rs
//   alu_src_b_o       ALU B: 00=rt, 01=4, 10=imm, 11=imm<<2
//   alu_op_o          00=add, 01=sub, 10=funct-decoded
//   reg_dst_o         write register: 0=rt, 1=rd
//   mem_to_reg_o      writeback data: 0=ALUOut, 1=memory data
//   reg_write_o       register file write enable
//   instr_done_o      one-cycle pulse when an instruction retires
//   illegal_o         one-cycle pulse on an unsupported opcode
//   bus_err_o         sticky memory-timeout flag
//   state_o           current state encoding (debug)
//   instr_cnt_o       retired-instruction count (wrapping)
module multicycle_ctrl #(
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned CNT_W        = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [5:0]  op_i,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        i_or_d_o,
  output logic        ir_write_o,
  output logic        pc_write_o,
  output logic [1:0]  pc_src_o,
  output logic        alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [1:0]  alu_op_o,
  output logic        reg_dst_o,
  output logic        mem_to_reg_o,
  output logic        reg_write_o,
  output logic        instr_done_o,
  output logic        illegal_o,
  output logic        bus_err_o,
  output logic [3:0]  state_o,
  output logic [31:0] instr_cnt_o
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAddr = 4'd2,
    StMemRd   = 4'd3,
    StLwWb    = 4'd4,
    StMemWr   = 4'd5,
    StRExec   = 4'd6,
    StRWb     = 4'd7,
    StIExec   = 4'd8,
    StIWb     = 4'd9,
    StBranch  = 4'd10,
    StJump    = 4'd11,
    StErr     = 4'd15
  } state_e;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [CNT_W-1:0] WaitMax = CNT_W'(MEM_WAIT_MAX);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wait_q, wait_d;
  logic [31:0]        instr_cnt_q, instr_cnt_d;

  logic       mem_req_c, mem_we_c, i_or_d_c, ir_write_c, pc_write_c;
  logic [1:0] pc_src_c, alu_src_b_c, alu_op_c;
  logic       alu_src_a_c, reg_dst_c, mem_to_reg_c, reg_write_c;
  logic       instr_done_c, illegal_c;
  logic       in_mem_state;

  always_comb begin
    state_d      = state_q;
    mem_req_c    = 1'b0;
    mem_we_c     = 1'b0;
    i_or_d_c     = 1'b0;
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    pc_src_c     = 2'b00;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = 2'b00;
    alu_op_c     = 2'b00;
    reg_dst_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    reg_write_c  = 1'b0;
    instr_done_c = 1'b0;
    illegal_c    = 1'b0;
    in_mem_state = 1'b0;

    unique case (state_q)
      StFetch: begin
        in_mem_state = 1'b1;
        mem_req_c    = 1'b1;
        alu_src_b_c  = 2'b01;
        ir_write_c   = mem_ready_i;
        pc_write_c   = mem_ready_i;
        if (mem_ready_i) state_d = StDecode;
      end
      StDecode: begin
        // Branch target is precomputed here while the opcode is decoded
        alu_src_b_c = 2'b11;
        case (op_i)
          OpRType:    state_d = StRExec;
          OpAddi:     state_d = StIExec;
          OpLw, OpSw: state_d = StMemAddr;
          OpBeq:      state_d = StBranch;
          OpJ:        state_d = StJump;
          default: begin
            illegal_c = 1'b1;
            state_d   = StFetch;
          end
        endcase
      end
      StMemAddr: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        state_d     = (op_i == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        in_mem_state = 1'b1;
        mem_req_c    = 1'b1;
        i_or_d_c     = 1'b1;
        if (mem_ready_i) state_d = StLwWb;
      end
      StLwWb: begin
        mem_to_reg_c = 1'b1;
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
        state_d      = StFetch;
      end
      StMemWr: begin
        in_mem_state = 1'b1;
        mem_req_c    = 1'b1;
        mem_we_c     = 1'b1;
        i_or_d_c     = 1'b1;
        instr_done_c = mem_ready_i;
        if (mem_ready_i) state_d = StFetch;
      end
      StRExec: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = 2'b10;
        state_d     = StRWb;
      end
      StRWb: begin
        reg_dst_c    = 1'b1;
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
        state_d      = StFetch;
      end
      StIExec: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        state_d     = StIWb;
      end
      StIWb: begin
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
        state_d      = StFetch;
      end
      StBranch: begin
        alu_src_a_c  = 1'b1;
        alu_op_c     = 2'b01;
        pc_src_c     = 2'b01;
        pc_write_c   = zero_i;
        instr_done_c = 1'b1;
        state_d      = StFetch;
      end
      StJump: begin
        pc_src_c     = 2'b10;
        pc_write_c   = 1'b1;
        instr_done_c = 1'b1;
        state_d      = StFetch;
      end
      StErr: state_d = StErr;
      default: state_d = StFetch;
    endcase

    // Timeout: a ready arriving on the last allowed cycle still wins
    if (in_mem_state && !mem_ready_i && (MEM_WAIT_MAX != 0) && (wait_q == WaitMax)) begin
      state_d = StErr;
    end
  end

  // Counts unanswered cycles within one memory state; saturates so a disabled timeout never wraps
  always_comb begin
    wait_d = '0;
    if (in_mem_state && !mem_ready_i && (state_d == state_q)) begin
      wait_d = (wait_q == {CNT_W{1'b1}}) ? wait_q : wait_q + 1'b1;
    end
  end

  always_comb begin
    instr_cnt_d = instr_cnt_q;
    if (instr_done_c) instr_cnt_d = instr_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= StFetch;
      wait_q      <= '0;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  // Control outputs are held low for as long as reset is asserted
  assign mem_req_o    = rst_i & mem_req_c;
  assign mem_we_o     = rst_i & mem_we_c;
  assign i_or_d_o     = rst_i & i_or_d_c;
  assign ir_write_o   = rst_i & ir_write_c;
  assign pc_write_o   = rst_i & pc_write_c;
  assign pc_src_o     = {2{rst_i}} & pc_src_c;
  assign alu_src_a_o  = rst_i & alu_src_a_c;
  assign alu_src_b_o  = {2{rst_i}} & alu_src_b_c;
  assign alu_op_o     = {2{rst_i}} & alu_op_c;
  assign reg_dst_o    = rst_i & reg_dst_c;
  assign mem_to_reg_o = rst_i & mem_to_reg_c;
  assign reg_write_o  = rst_i & reg_write_c;
  assign instr_done_o = rst_i & instr_done_c;
  assign illegal_o    = rst_i & illegal_c;
  assign bus_err_o    = (state_q == StErr);
  assign state_o      = state_q;
  assign instr_cnt_o  = instr_cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [5:0]  op_i;
  logic        zero_i;
  logic        mem_ready_i;
  logic        mem_req_o, mem_we_o, i_or_d_o, ir_write_o, pc_write_o;
  logic [1:0]  pc_src_o, alu_src_b_o, alu_op_o;
  logic        alu_src_a_o, reg_dst_o, mem_to_reg_o, reg_write_o;
  logic        instr_done_o, illegal_o, bus_err_o;
  logic [3:0]  state_o;
  logic [31:0] instr_cnt_o;

  int n_total = 0;
  int n_bad   = 0;

  multicycle_ctrl #(
    .MEM_WAIT_MAX(15),
    .CNT_W       (8)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .op_i        (op_i),
    .zero_i      (zero_i),
    .mem_ready_i (mem_ready_i),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .i_or_d_o    (i_or_d_o),
    .ir_write_o  (ir_write_o),
    .pc_write_o  (pc_write_o),
    .pc_src_o    (pc_src_o),
    .alu_src_a_o (alu_src_a_o),
    .alu_src_b_o (alu_src_b_o),
    .alu_op_o    (alu_op_o),
    .reg_dst_o   (reg_dst_o),
    .mem_to_reg_o(mem_to_reg_o),
    .reg_write_o (reg_write_o),
    .instr_done_o(instr_done_o),
    .illegal_o   (illegal_o),
    .bus_err_o   (bus_err_o),
    .state_o     (state_o),
    .instr_cnt_o (instr_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs may be changed right after, then settle() before checking
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_i       = 1'b0;
    op_i        = 6'b000000;
    zero_i      = 1'b0;
    mem_ready_i = 1'b1;
    #12;
    chk("rst_state", state_o, 0);
    chk("rst_req", mem_req_o, 0);
    chk("rst_irw", ir_write_o, 0);
    chk("rst_cnt", instr_cnt_o, 0);
    chk("rst_err", bus_err_o, 0);

    // R-type: 0,1,6,7,0
    tick(); rst_i = 1'b1; settle();
    chk("r_fetch", state_o, 0);
    chk("r_fetch_req", {mem_req_o, i_or_d_o, ir_write_o, pc_write_o, alu_src_b_o}, 6'b101101);
    tick(); chk("r_dec", state_o, 1);
    chk("r_dec_srcb", alu_src_b_o, 2'b11);
    chk("r_dec_rw", reg_write_o, 0);
    tick(); chk("r_exec", state_o, 6);
    chk("r_exec_ctl", {alu_src_a_o, alu_src_b_o, alu_op_o, reg_write_o}, 6'b100100);
    tick(); chk("r_wb", state_o, 7);
    chk("r_wb_ctl", {reg_dst_o, reg_write_o, instr_done_o}, 3'b111);
    tick(); chk("r_back", state_o, 0);
    chk("r_cnt", instr_cnt_o, 1);

    // lw: 0,1,2,3,4,0
    op_i = 6'b100011;
    tick(); chk("lw_dec", state_o, 1);
    tick(); chk("lw_addr", state_o, 2);
    chk("lw_addr_ctl", {alu_src_a_o, alu_src_b_o, alu_op_o}, 5'b11000);
    tick(); chk("lw_rd", state_o, 3);
    chk("lw_rd_ctl", {mem_req_o, mem_we_o, i_or_d_o}, 3'b101);
    tick(); chk("lw_wb", state_o, 4);
    chk("lw_wb_ctl", {mem_to_reg_o, reg_write_o, reg_dst_o, instr_done_o}, 4'b1101);
    tick(); chk("lw_back", state_o, 0);
    chk("lw_cnt", instr_cnt_o, 2);

    // beq taken then not taken
    op_i = 6'b000100; zero_i = 1'b1;
    tick(); tick(); chk("beq1_st", state_o, 10);
    chk("beq1_ctl", {pc_write_o, pc_src_o, alu_op_o, instr_done_o}, 6'b101011);
    tick(); chk("beq1_back", state_o, 0);
    zero_i = 1'b0;
    tick(); tick(); chk("beq0_st", state_o, 10);
    chk("beq0_pcw", pc_write_o, 0);
    tick(); chk("beq_cnt", instr_cnt_o, 4);

    // sw with three wait cycles in MEM_WR
    op_i = 6'b101011;
    tick(); tick(); chk("sw_addr", state_o, 2);
    tick(); mem_ready_i = 1'b0; settle();
    for (int i = 0; i < 3; i++) begin
      chk("sw_wait_st", state_o, 5);
      chk("sw_wait_ctl", {mem_req_o, mem_we_o, i_or_d_o, instr_done_o}, 4'b1110);
      tick();
    end
    mem_ready_i = 1'b1; settle();
    chk("sw_last_st", state_o, 5);
    chk("sw_last_ctl", {mem_req_o, mem_we_o, i_or_d_o, instr_done_o}, 4'b1111);
    tick(); chk("sw_back", state_o, 0);
    chk("sw_cnt", instr_cnt_o, 5);

    // j
    op_i = 6'b000010;
    tick(); tick(); chk("j_st", state_o, 11);
    chk("j_ctl", {pc_write_o, pc_src_o, instr_done_o}, 4'b1101);
    tick(); chk("j_cnt", instr_cnt_o, 6);

    // addi: 0,1,8,9,0
    op_i = 6'b001000;
    tick(); tick(); chk("addi_exec", state_o, 8);
    chk("addi_exec_ctl", {alu_src_a_o, alu_src_b_o, alu_op_o}, 5'b11000);
    tick(); chk("addi_wb", state_o, 9);
    chk("addi_wb_ctl", {reg_dst_o, reg_write_o, instr_done_o}, 3'b011);
    tick(); chk("addi_cnt", instr_cnt_o, 7);

    // Illegal opcode
    op_i = 6'b111111;
    tick(); chk("ill_dec", state_o, 1);
    chk("ill_pulse", {illegal_o, instr_done_o}, 2'b10);
    tick(); chk("ill_back", state_o, 0);
    chk("ill_pulse_gone", illegal_o, 0);
    chk("ill_cnt", instr_cnt_o, 7);

    // Ready arrives on the 16th FETCH cycle: no error
    op_i = 6'b000010; mem_ready_i = 1'b0; settle();
    for (int i = 0; i < 15; i++) begin
      chk("to_ok_wait", state_o, 0);
      tick();
    end
    mem_ready_i = 1'b1; settle();
    chk("to_ok_16", {state_o, ir_write_o}, 5'b00001);
    tick(); chk("to_ok_dec", {state_o, bus_err_o}, 5'b00010);
    tick(); tick(); chk("to_ok_cnt", instr_cnt_o, 8);

    // No ready for 16 FETCH cycles: ERR
    mem_ready_i = 1'b0; settle();
    for (int i = 0; i < 16; i++) begin
      chk("to_err_wait", {state_o, mem_req_o}, 5'b00001);
      tick();
    end
    chk("to_err_st", state_o, 15);
    chk("to_err_flag", {bus_err_o, mem_req_o, ir_write_o, pc_write_o}, 4'b1000);
    mem_ready_i = 1'b1;
    tick(); tick(); chk("to_err_sticky", {state_o, bus_err_o}, 5'b11111);
    rst_i = 1'b0; settle();
    chk("to_err_rst", {state_o, bus_err_o}, 5'b00000);
    chk("to_err_rst_cnt", instr_cnt_o, 0);
    tick(); rst_i = 1'b1;

    // Reset asserted during MEM_RD abandons the access
    op_i = 6'b100011; settle();
    tick(); tick(); tick(); mem_ready_i = 1'b0; settle();
    chk("rd_st", {state_o, mem_req_o, i_or_d_o}, 6'b001111);
    #1 rst_i = 1'b0; settle();
    chk("rd_rst", {state_o, mem_req_o, i_or_d_o, mem_we_o}, 7'b0000000);
    tick(); rst_i = 1'b1; mem_ready_i = 1'b1; settle();
    chk("rd_rel", {state_o, mem_req_o, i_or_d_o}, 6'b000010);
    tick(); chk("rd_rel_dec", state_o, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
